// File: rtl/ls1u_bus_pkg.sv
// Shared LS1u bus-responder types: FSM state and op encodings, default wait states.
package ls1u_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  localparam int unsigned DEF_WS = 2;

endpackage

// File: rtl/ls1u_dbus_responder_if.sv
// LS1u CPU byte data bus: CPU drives master, the memory responder sits on slave.
interface ls1u_dbus_responder_if #(
  parameter int unsigned AW = 24
);
  logic [AW-1:0] daddr;
  logic          dread;
  logic          dwrite;
  logic [7:0]    ddata_o;
  logic [7:0]    ddata_i;
  logic          WAIT_DATA;

  modport master (
    output daddr, dread, dwrite, ddata_o,
    input  ddata_i, WAIT_DATA
  );

  modport slave (
    input  daddr, dread, dwrite, ddata_o,
    output ddata_i, WAIT_DATA
  );
endinterface

// File: rtl/ls1u_ws_counter.sv
// Wait-state down-counter: load, decrement-to-zero (saturating), zero flag.
module ls1u_ws_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ls1u_dbus_responder.sv
// LS1u data-bus responder: turns CPU byte requests into timed async SRAM/flash cycles.
// Optional macro LS1U_DBUS_MEM_RDY_EN adds mem_rdy to stretch ACCESS until the device is ready.
module ls1u_dbus_responder
  import ls1u_bus_pkg::*;
#(
  parameter int unsigned AW    = 24,
  parameter int unsigned RD_WS = DEF_WS,
  parameter int unsigned WR_WS = 1,
  parameter int unsigned CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  ls1u_dbus_responder_if.slave   cpu,
  output logic [AW-1:0]          mem_addr,
  output logic [7:0]             mem_dq_o,
  output logic                   mem_dq_oe,
  input  logic [7:0]             mem_dq_i,
`ifdef LS1U_DBUS_MEM_RDY_EN
  input  logic                   mem_rdy,
`endif
  output logic                   mem_ce_n,
  output logic                   mem_oe_n,
  output logic                   mem_we_n
);

  state_t           state, state_nxt;
  op_t              op;
  logic             req;
  logic             exit_ok;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ws_load;
  logic             latch, capture;
  logic             ce_n_nxt, oe_n_nxt, we_n_nxt, dq_oe_nxt;
  logic [7:0]       ddata_q;

  assign req           = cpu.dread | cpu.dwrite;
  assign cpu.WAIT_DATA = req & (state != ACK);
  assign cpu.ddata_i   = ddata_q;
  assign ws_load       = cpu.dwrite ? CNT_W'(WR_WS) : CNT_W'(RD_WS);

`ifdef LS1U_DBUS_MEM_RDY_EN
  assign exit_ok = cnt_zero & mem_rdy;
`else
  assign exit_ok = cnt_zero;
`endif

  ls1u_ws_counter #(
    .CNT_W(CNT_W)
  ) u_ws_counter (
    .clk      (clk),
    .rst_n    (rst),
    .load     (cnt_load),
    .load_val (ws_load),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Strobes are computed for the next cycle and registered so the pads never glitch;
  // every default is the inactive level, so abort and ACK exit simply fall through.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    latch     = 1'b0;
    capture   = 1'b0;
    ce_n_nxt  = 1'b1;
    oe_n_nxt  = 1'b1;
    we_n_nxt  = 1'b1;
    dq_oe_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = ACCESS;
          cnt_load  = 1'b1;
          latch     = 1'b1;
          ce_n_nxt  = 1'b0;
          if (cpu.dwrite) begin
            we_n_nxt  = 1'b0;
            dq_oe_nxt = 1'b1;
          end else begin
            oe_n_nxt  = 1'b0;
          end
        end
      end
      ACCESS: begin
        if (!req) begin
          state_nxt = IDLE;
        end else if (exit_ok) begin
          state_nxt = ACK;
          capture   = (op == OP_RD);
          dq_oe_nxt = (op == OP_WR);
        end else begin
          cnt_dec   = 1'b1;
          ce_n_nxt  = 1'b0;
          oe_n_nxt  = (op == OP_WR);
          we_n_nxt  = (op == OP_RD);
          dq_oe_nxt = (op == OP_WR);
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op        <= OP_RD;
      mem_addr  <= '0;
      mem_dq_o  <= '0;
      ddata_q   <= '0;
      mem_ce_n  <= 1'b1;
      mem_oe_n  <= 1'b1;
      mem_we_n  <= 1'b1;
      mem_dq_oe <= 1'b0;
    end else begin
      if (latch) begin
        mem_addr <= cpu.daddr;
        mem_dq_o <= cpu.ddata_o;
        op       <= cpu.dwrite ? OP_WR : OP_RD;
      end
      if (capture) ddata_q <= mem_dq_i;
      mem_ce_n  <= ce_n_nxt;
      mem_oe_n  <= oe_n_nxt;
      mem_we_n  <= we_n_nxt;
      mem_dq_oe <= dq_oe_nxt;
    end
  end

endmodule

// File: doc/ls1u_dbus_responder.md
Name: ls1u_dbus_responder

Overview:
- Target-side responder for the LS1u CPU byte data bus (daddr/dread/dwrite/ddata_o/ddata_i/WAIT_DATA).
- Converts each CPU data request into a timed access on an external 8-bit asynchronous SRAM/flash port, with programmable read and write wait states.
- Holds the CPU with WAIT_DATA until the access completes.
- Sits between the CPU wrapper data port and the off-chip memory pads.

Parameters:
- AW, 24, address width of daddr and mem_addr.
- RD_WS, 2, extra wait cycles in ACCESS for reads (0..2^CNT_W-1).
- WR_WS, 1, extra wait cycles in ACCESS for writes (0..2^CNT_W-1).
- CNT_W, 4, wait-state counter width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- daddr  input  AW  CPU data address; stable while WAIT_DATA=1.
- dread  input  1  CPU read request; level, held until WAIT_DATA=0.
- dwrite  input  1  CPU write request; level, held until WAIT_DATA=0.
- ddata_o  input  8  CPU write data.
- ddata_i  output  8  read data to the CPU.
- WAIT_DATA  output  1  stall to the CPU; combinational.
- mem_addr  output  AW  registered memory address.
- mem_dq_o  output  8  registered write data.
- mem_dq_oe  output  1  pad output enable for mem_dq.
- mem_dq_i  input  8  memory read data.
- mem_ce_n  output  1  chip enable, active-low.
- mem_oe_n  output  1  output enable, active-low.
- mem_we_n  output  1  write enable, active-low.

Behaviour:
- Reset values: state=IDLE, cnt=0, ddata_i=0, mem_addr=0, mem_dq_o=0, mem_dq_oe=0, mem_ce_n=1, mem_oe_n=1, mem_we_n=1.
- req = dread|dwrite. Write has priority when both are high.
- WAIT_DATA = req & (state!=ACK). It is 0 whenever req=0.
- IDLE: if req, then:
  - latch daddr into mem_addr and ddata_o into mem_dq_o;
  - latch op=dwrite;
  - load cnt=WS (WR_WS for writes, RD_WS for reads);
  - go to ACCESS.
- ACCESS:
  - mem_ce_n=0.
  - Read: mem_oe_n=0.
  - Write: mem_we_n=0 and mem_dq_oe=1.
  - While cnt!=0, decrement cnt.
  - When cnt==0: if read, capture mem_dq_i into ddata_i; go to ACK.
- ACK:
  - WAIT_DATA=0; the CPU completes at this edge.
  - Strobes deassert: mem_oe_n=1, mem_we_n=1, mem_ce_n=1.
  - mem_dq_oe stays 1 through ACK for write data hold, then clears.
  - Go to IDLE.
- Latency: request held WS+3 cycles. WAIT_DATA is high for WS+2 cycles. Examples: RD_WS=0 gives 3 cycles; RD_WS=2 gives 5 cycles.
- ddata_i holds its last captured value until the next read capture. Writes do not change it.
- Back-to-back: a request present in IDLE is always a new access. This includes a request still held one cycle after ACK, so the CPU must drop or change the request at the ACK edge.
- Abort: if req falls while in ACCESS (CPU flush or interrupt):
  - go to IDLE next cycle;
  - deassert all strobes and mem_dq_oe;
  - ddata_i is not updated.
- Changing daddr during ACCESS is ignored; the latched mem_addr is used.
- Asynchronous reset mid-access forces every strobe inactive immediately, without waiting for clk.

Optional Feature:
- Macro: LS1U_DBUS_MEM_RDY_EN.
- With the macro: adds port mem_rdy (input, 1). The ACCESS exit condition becomes (cnt==0 & mem_rdy), so slow or external devices can extend the access indefinitely. Read data is captured on the exiting edge.
- Without the macro: the port is absent and the exit condition is cnt==0 only.

Decomposition:
- Shared package ls1u_bus_pkg holds:
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, ACK=2'd2);
  - the op encoding (OP_RD=0, OP_WR=1);
  - a default wait-state constant.
- One natural sub-module: ls1u_ws_counter (load/decrement/zero-flag, CNT_W wide). Reused later for the instruction-fetch responder.

Test Plan:
- Read, RD_WS=2: daddr=24'h001234, dread=1, mem_dq_i=8'hA5 → WAIT_DATA high 4 cycles, then low 1 cycle; ddata_i=8'hA5; mem_oe_n low exactly 3 cycles; mem_addr=24'h001234.
- Write, WR_WS=1: dwrite=1, ddata_o=8'h3C → mem_we_n low 2 cycles; mem_dq_o=8'h3C; mem_dq_oe high 3 cycles; WAIT_DATA high 3 cycles; ddata_i unchanged.
- dread=dwrite=1 together → write cycle performed (mem_we_n low, mem_oe_n stays high).
- Abort: dread dropped on the 2nd ACCESS cycle → IDLE next cycle; all strobes high; ddata_i keeps its previous value 8'h00.
- Back-to-back: two reads at 24'h10 and 24'h11 presented consecutively → two distinct accesses, each 5 cycles; mem_addr steps 10→11.
- rst asserted low during write ACCESS → mem_we_n=1 and mem_dq_oe=0 asynchronously, before the next clk edge; state=IDLE after release. With LS1U_DBUS_MEM_RDY_EN, holding mem_rdy=0 for 6 cycles extends WAIT_DATA by 6 cycles.
